input_frame_buffer: RTL and testbench
=====================================

INPUT_FRAME_BUFFER -- requirements
Module: input_frame_buffer

Interface
REQ-001 SHALL have parameter N_INPUTS, default 49, number of pixels per frame (7x7 image).
REQ-002 SHALL have parameter PIX_W, default 8, pixel width in bits, unsigned.
REQ-003 SHALL have port clk  input  1  single clock, all logic on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port pix_valid  input  1  pixel stream valid.
REQ-006 SHALL have port pix_sof  input  1  marks the first pixel of a frame; qualified by pix_valid.
REQ-007 SHALL have port pix_data  input  PIX_W  pixel value.
REQ-008 SHALL have port pix_ready  output  1  buffer can accept a pixel this cycle.
REQ-009 SHALL have port frame_valid  output  1  complete frame presented on frame_data.
REQ-010 SHALL have port frame_ready  input  1  downstream neuron layer takes the frame.
REQ-011 SHALL have port frame_data  output  N_INPUTS x 32-bit signed integer array  pixel i zero-extended into element i; drives the neuron layer input_in.
REQ-012 SHALL have port sof_err  output  1  one-cycle pulse on frame resync.
REQ-013 SHALL have port frame_cnt  output  16  count of frames handed off, wraps 0xFFFF->0.

Function
REQ-014 SHALL accept a pixel only on pix_valid && pix_ready, storing it at the write index, then incrementing the index.
REQ-015 SHALL, on accepting the pixel at index N_INPUTS-1, mark the fill bank full and reset the index to 0; frame_valid SHALL rise on the next clock edge (1-cycle latency).
REQ-016 SHALL hold frame_data and frame_valid stable while frame_valid && !frame_ready.
REQ-017 SHALL complete a handoff on frame_valid && frame_ready, free that bank, and increment frame_cnt on the same edge.
REQ-018 SHALL, when an accepted pixel has pix_sof=1 and the index is not 0, discard the partial frame, store that pixel at index 0, set the index to 1, and pulse sof_err for one cycle.
REQ-019 SHALL treat pix_sof=1 at index 0 as normal, with no sof_err.
REQ-020 SHALL not require pix_sof; frames are delimited by count alone.
REQ-021 SHALL, when N_INPUTS-1 is accepted in the same cycle a handoff completes, perform both operations with no lost frame or pixel.
REQ-022 SHALL deliver frames in arrival order.
REQ-023 SHALL drive pix_ready from registered state only, with no combinational path from frame_ready.

Reset
REQ-024 SHALL, on rst_n low, asynchronously clear the index to 0, all banks to empty, frame_valid to 0, frame_data to all 0, sof_err to 0, and frame_cnt to 0.
REQ-025 SHALL assert pix_ready=1 from the first clock edge after rst_n deasserts.
REQ-026 SHALL, when reset occurs mid-frame, discard the partial frame and start the next frame at index 0.

Configuration
REQ-027 SHALL use macro INPUT_FRAME_BUFFER_PINGPONG_EN.
- Defined: two banks; fill one bank while the other is presented; pix_ready=0 only when both banks are full.
- Undefined: single bank; pix_ready=0 from the cycle after the bank fills until the cycle after handoff.

Structure
REQ-028 SHALL place N_INPUTS default, PIX_W default, the 32-bit frame element typedef and the frame array typedef in shared package nn_pkg.
REQ-029 SHALL implement each bank as sub-module frame_bank (N_INPUTS registers, indexed write, clear, parallel read).

Verification
REQ-030 SHALL cover: reset, then 49 pixels of value 1..49 with frame_ready=1 -> frame_valid rises 1 cycle after the 49th pixel, frame_data[i]=i+1, frame_cnt=1.
REQ-031 SHALL cover: frame_ready=0 for 20 cycles after frame_valid -> frame_data stable; pingpong build: second frame of 49 pixels accepted, pix_ready=0 at the 1st pixel of the third frame; single-bank build: pix_ready=0 at the 1st pixel of the second frame.
REQ-032 SHALL cover: pix_sof at pixel 10 of a frame -> sof_err pulses once, frame completes 48 pixels later, and that frame's frame_data[0] is the sof pixel.
REQ-033 SHALL cover: 49th pixel accepted in the same cycle as a handoff (pingpong build) -> next frame_valid follows with no gap, frame_cnt increments by 1.
REQ-034 SHALL cover: rst_n pulsed low after 30 pixels -> outputs are at reset values immediately, and the next 49 pixels form a complete frame.
REQ-035 SHALL cover: preload frame_cnt=0xFFFF, one handoff -> frame_cnt=0.

Source files
------------

// File: rtl/nn_pkg.sv
// Shared definitions for the input frame buffer and the neuron layer it feeds:
// default frame geometry, the 32-bit frame element type and the frame array type.
package nn_pkg;

  localparam int N_INPUTS_DEF = 49;  // 7x7 image
  localparam int PIX_W_DEF    = 8;

  typedef logic signed [31:0] elem_t;
  typedef elem_t frame_t [N_INPUTS_DEF];

  // Width of a pixel index into a frame of n pixels (at least one bit).
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/frame_bank.sv
// One frame of pixel storage: N_INPUTS registers with an indexed write port,
// a synchronous clear and a parallel read of every pixel zero-extended to 32 bits.
module frame_bank
  import nn_pkg::*;
#(
  parameter int N_INPUTS = N_INPUTS_DEF,
  parameter int PIX_W    = PIX_W_DEF
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           clear,
  input  logic                           wr_en,
  input  logic [idx_width(N_INPUTS)-1:0] wr_idx,
  input  logic [PIX_W-1:0]               wr_data,
  output elem_t                          rd_data [N_INPUTS]
);

  localparam int IDX_W = idx_width(N_INPUTS);

  logic [PIX_W-1:0] mem [N_INPUTS];

  // Pixel storage: a write wins over clear so a resync pixel lands at its slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_INPUTS; i++) mem[i] <= '0;
    end else begin
      for (int i = 0; i < N_INPUTS; i++) begin
        if (wr_en && (wr_idx == IDX_W'(i))) mem[i] <= wr_data;
        else if (clear)                      mem[i] <= '0;
      end
    end
  end

  // Parallel read, pixels are unsigned so they are zero-extended.
  always_comb begin
    for (int i = 0; i < N_INPUTS; i++) rd_data[i] = elem_t'(32'(mem[i]));
  end

endmodule

// File: rtl/input_frame_buffer.sv
// Collects a pixel stream into whole frames and hands each frame to the neuron
// layer as a parallel array.
// Build option: define INPUT_FRAME_BUFFER_PINGPONG_EN for two banks (fill one
// while the other is presented); leave it undefined for a single bank.
//
// Handshakes: a transfer happens on a rising edge where valid && ready are both
// high. The producer holds valid and data until that edge; ready never depends
// combinationally on valid. pix_ready is a function of registered state only,
// and frame_valid/frame_data stay stable until frame_ready is seen.
//
// FRAME_CNT_INIT is the value frame_cnt takes under reset (0 in normal use).
module input_frame_buffer
  import nn_pkg::*;
#(
  parameter int          N_INPUTS       = N_INPUTS_DEF,
  parameter int          PIX_W          = PIX_W_DEF,
  parameter logic [15:0] FRAME_CNT_INIT = 16'h0000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pix_valid,
  input  logic             pix_sof,
  input  logic [PIX_W-1:0] pix_data,
  output logic             pix_ready,
  output logic             frame_valid,
  input  logic             frame_ready,
  output elem_t            frame_data [N_INPUTS],
  output logic             sof_err,
  output logic [15:0]      frame_cnt
);

  localparam int                IDX_W    = idx_width(N_INPUTS);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(N_INPUTS - 1);

  logic [IDX_W-1:0] wr_idx;
  logic [IDX_W-1:0] bank_idx;
  logic             accept;
  logic             resync;
  logic             last_pix;
  logic             handoff;

  assign accept   = pix_valid && pix_ready;
  // A start-of-frame marker mid-frame abandons the partial frame.
  assign resync   = accept && pix_sof && (wr_idx != '0);
  assign last_pix = accept && !resync && (wr_idx == LAST_IDX);
  assign bank_idx = resync ? '0 : wr_idx;

  // Write index, resync pulse and handoff counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_idx    <= '0;
      sof_err   <= 1'b0;
      frame_cnt <= FRAME_CNT_INIT;
    end else begin
      sof_err <= resync;
      if (accept) begin
        if (resync)                  wr_idx <= IDX_W'(1);
        else if (wr_idx == LAST_IDX) wr_idx <= '0;
        else                         wr_idx <= wr_idx + IDX_W'(1);
      end
      if (handoff) frame_cnt <= frame_cnt + 16'd1;
    end
  end

`ifdef INPUT_FRAME_BUFFER_PINGPONG_EN

  logic [1:0] full;      // per-bank "holds a complete frame"
  logic       fill_sel;  // bank receiving pixels
  logic       pres_sel;  // bank presented downstream (oldest full bank)
  elem_t      rd0 [N_INPUTS];
  elem_t      rd1 [N_INPUTS];

  assign pix_ready   = ~&full;
  assign frame_valid = full[pres_sel];
  assign handoff     = frame_valid && frame_ready;

  // Bank occupancy: a fill and a handoff in the same cycle touch different banks.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full     <= 2'b00;
      fill_sel <= 1'b0;
      pres_sel <= 1'b0;
    end else begin
      if (last_pix) begin
        full[fill_sel] <= 1'b1;
        fill_sel       <= ~fill_sel;
      end
      if (handoff) begin
        full[pres_sel] <= 1'b0;
        pres_sel       <= ~pres_sel;
      end
    end
  end

  frame_bank #(.N_INPUTS(N_INPUTS), .PIX_W(PIX_W)) u_bank0 (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (resync && !fill_sel),
    .wr_en   (accept && !fill_sel),
    .wr_idx  (bank_idx),
    .wr_data (pix_data),
    .rd_data (rd0)
  );

  frame_bank #(.N_INPUTS(N_INPUTS), .PIX_W(PIX_W)) u_bank1 (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (resync && fill_sel),
    .wr_en   (accept && fill_sel),
    .wr_idx  (bank_idx),
    .wr_data (pix_data),
    .rd_data (rd1)
  );

  // Present the bank holding the oldest complete frame.
  always_comb begin
    for (int i = 0; i < N_INPUTS; i++) frame_data[i] = pres_sel ? rd1[i] : rd0[i];
  end

`else

  logic full;  // the single bank holds a complete frame

  assign pix_ready   = !full;
  assign frame_valid = full;
  assign handoff     = full && frame_ready;

  // Bank occupancy: filling and handing off are mutually exclusive here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        full <= 1'b0;
    else if (last_pix) full <= 1'b1;
    else if (handoff)  full <= 1'b0;
  end

  frame_bank #(.N_INPUTS(N_INPUTS), .PIX_W(PIX_W)) u_bank0 (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (resync),
    .wr_en   (accept),
    .wr_idx  (bank_idx),
    .wr_data (pix_data),
    .rd_data (frame_data)
  );

`endif

endmodule

// File: tb/tb_input_frame_buffer.sv
// Directed bench for input_frame_buffer: reset, frame fill and handoff,
// backpressure hold, mid-frame resync, reset mid-frame and counter wrap.
// Works for both builds (INPUT_FRAME_BUFFER_PINGPONG_EN defined or not).
module tb_input_frame_buffer;
  import nn_pkg::*;

  localparam int N  = 49;
  localparam int WN = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // ---------------- main DUT signals ----------------
  logic        pix_valid, pix_sof, pix_ready;
  logic [7:0]  pix_data;
  logic        frame_valid, frame_ready, sof_err;
  frame_t      frame_data;
  logic [15:0] frame_cnt;

  // ---------------- wrap DUT signals (small frame, counter preset) ----------------
  logic        w_pix_valid, w_pix_sof, w_pix_ready;
  logic [7:0]  w_pix_data;
  logic        w_frame_valid, w_frame_ready, w_sof_err;
  elem_t       w_frame_data [WN];
  logic [15:0] w_frame_cnt;

  input_frame_buffer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pix_valid   (pix_valid),
    .pix_sof     (pix_sof),
    .pix_data    (pix_data),
    .pix_ready   (pix_ready),
    .frame_valid (frame_valid),
    .frame_ready (frame_ready),
    .frame_data  (frame_data),
    .sof_err     (sof_err),
    .frame_cnt   (frame_cnt)
  );

  input_frame_buffer #(.N_INPUTS(WN), .PIX_W(8), .FRAME_CNT_INIT(16'hFFFF)) dut_w (
    .clk         (clk),
    .rst_n       (rst_n),
    .pix_valid   (w_pix_valid),
    .pix_sof     (w_pix_sof),
    .pix_data    (w_pix_data),
    .pix_ready   (w_pix_ready),
    .frame_valid (w_frame_valid),
    .frame_ready (w_frame_ready),
    .frame_data  (w_frame_data),
    .sof_err     (w_sof_err),
    .frame_cnt   (w_frame_cnt)
  );

  // ---------------- scoreboard ----------------
  logic [31:0] exp_q[$];
  logic [31:0] cur_exp [N];
  int          tests_run = 0;
  int          tests_failed = 0;
  int          exp_cnt = 0;
  int          sof_pulses;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Compare the presented frame against the oldest expected frame.
  task automatic check_frame(input string tag);
    logic [31:0] e;
    for (int i = 0; i < N; i++) begin
      if (exp_q.size() == 0) begin
        check({tag, "_queue"}, frame_data[i], 32'hDEAD_BEEF);
        return;
      end
      e = exp_q.pop_front();
      cur_exp[i] = e;
      check($sformatf("%s[%0d]", tag, i), frame_data[i], e);
    end
  endtask

  // ---------------- driver ----------------
  // Called at a falling edge; returns at the falling edge after acceptance.
  task automatic send_pixel(input logic [7:0] d, input logic sof, input logic track);
    int waited;
    waited    = 0;
    pix_valid = 1'b1;
    pix_data  = d;
    pix_sof   = sof;
    while (!pix_ready && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    if (!pix_ready) begin
      check("pix_ready_wait", {31'b0, pix_ready}, 32'd1);
    end else begin
      @(negedge clk);
      if (track) exp_q.push_back({24'b0, d});
    end
    pix_valid = 1'b0;
    pix_sof   = 1'b0;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b0;
    pix_valid = 1'b0; pix_sof = 1'b0; pix_data = '0; frame_ready = 1'b0;
    w_pix_valid = 1'b0; w_pix_sof = 1'b0; w_pix_data = '0; w_frame_ready = 1'b0;

    // Reset values
    repeat (2) @(negedge clk);
    check("rst_frame_valid", {31'b0, frame_valid}, 32'd0);
    check("rst_sof_err",     {31'b0, sof_err},     32'd0);
    check("rst_frame_cnt",   {16'b0, frame_cnt},   32'd0);
    check("rst_data0",       frame_data[0],        32'd0);
    check("rst_data48",      frame_data[48],       32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("pix_ready_after_rst", {31'b0, pix_ready}, 32'd1);

    // Frame 1..49, downstream always ready; sof at index 0 is not an error
    frame_ready = 1'b1;
    for (int i = 0; i < N; i++) begin
      send_pixel(8'(i + 1), (i == 0), 1'b1);
      if (i == 0)     check("sof_idx0_no_err", {31'b0, sof_err}, 32'd0);
      if (i == N - 2) check("valid_before_last", {31'b0, frame_valid}, 32'd0);
    end
    check("f1_valid", {31'b0, frame_valid}, 32'd1);
    check("f1_cnt_before", {16'b0, frame_cnt}, 32'd0);
    check_frame("f1_data");
    @(negedge clk);
    exp_cnt = 1;
    check("f1_cnt", {16'b0, frame_cnt}, 32'(exp_cnt));
    check("f1_valid_drop", {31'b0, frame_valid}, 32'd0);

    // Backpressure: frame held stable for 20 cycles
    frame_ready = 1'b0;
    for (int i = 0; i < N; i++) send_pixel(8'(100 + i), 1'b0, 1'b1);
    check("f2_valid", {31'b0, frame_valid}, 32'd1);
    check_frame("f2_data");
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      check("hold_valid", {31'b0, frame_valid}, 32'd1);
      check($sformatf("hold_data[%0d]", (c * 5) % N), frame_data[(c * 5) % N], cur_exp[(c * 5) % N]);
    end
    check("hold_cnt", {16'b0, frame_cnt}, 32'(exp_cnt));

`ifdef INPUT_FRAME_BUFFER_PINGPONG_EN
    // Second bank fills while the first is presented; third frame blocked
    for (int i = 0; i < N; i++) send_pixel(8'(1 + 3 * i), 1'b0, 1'b1);
    pix_valid = 1'b1; pix_data = 8'h55;
    check("pp_third_blocked", {31'b0, pix_ready}, 32'd0);
    @(negedge clk);
    check("pp_hold_data10", frame_data[10], cur_exp[10]);
    pix_valid = 1'b0;
    frame_ready = 1'b1;
    @(negedge clk);
    exp_cnt++;
    check("pp_cnt_a", {16'b0, frame_cnt}, 32'(exp_cnt));
    check("pp_next_valid", {31'b0, frame_valid}, 32'd1);
    check("pp_ready_back", {31'b0, pix_ready}, 32'd1);
    check_frame("pp_f3_data");
    @(negedge clk);
    exp_cnt++;
    check("pp_cnt_b", {16'b0, frame_cnt}, 32'(exp_cnt));
    check("pp_valid_drop", {31'b0, frame_valid}, 32'd0);
`else
    // Single bank: next frame's first pixel blocked until handoff
    pix_valid = 1'b1; pix_data = 8'h55;
    check("sb_second_blocked", {31'b0, pix_ready}, 32'd0);
    @(negedge clk);
    check("sb_still_blocked", {31'b0, pix_ready}, 32'd0);
    check("sb_hold_data0", frame_data[0], cur_exp[0]);
    pix_valid = 1'b0;
    frame_ready = 1'b1;
    @(negedge clk);
    exp_cnt++;
    check("sb_cnt", {16'b0, frame_cnt}, 32'(exp_cnt));
    check("sb_valid_drop", {31'b0, frame_valid}, 32'd0);
    check("sb_ready_back", {31'b0, pix_ready}, 32'd1);
`endif

    // Resync: sof on the 10th pixel
    frame_ready = 1'b1;
    for (int i = 0; i < 9; i++) send_pixel(8'(8'hF0 + i), 1'b0, 1'b0);
    send_pixel(8'hAA, 1'b1, 1'b1);
    check("resync_sof_err", {31'b0, sof_err}, 32'd1);
    sof_pulses = 0;
    for (int i = 0; i < N - 1; i++) begin
      send_pixel(8'(10 + i), 1'b0, 1'b1);
      if (sof_err) sof_pulses++;
      if (i == N - 3) check("resync_not_early", {31'b0, frame_valid}, 32'd0);
    end
    check("resync_single_pulse", 32'(sof_pulses), 32'd0);
    check("resync_valid", {31'b0, frame_valid}, 32'd1);
    check_frame("resync_data");
    @(negedge clk);
    exp_cnt++;
    check("resync_cnt", {16'b0, frame_cnt}, 32'(exp_cnt));

`ifdef INPUT_FRAME_BUFFER_PINGPONG_EN
    // Last pixel of frame B accepted on the same edge frame A is taken
    frame_ready = 1'b0;
    for (int i = 0; i < N; i++) send_pixel(8'(60 + i), 1'b0, 1'b1);
    check("sim_a_valid", {31'b0, frame_valid}, 32'd1);
    check_frame("sim_a_data");
    for (int i = 0; i < N - 1; i++) send_pixel(8'(180 - i), 1'b0, 1'b1);
    frame_ready = 1'b1;
    send_pixel(8'(180 - (N - 1)), 1'b0, 1'b1);
    exp_cnt++;
    check("sim_cnt_a", {16'b0, frame_cnt}, 32'(exp_cnt));
    check("sim_b_valid", {31'b0, frame_valid}, 32'd1);
    check_frame("sim_b_data");
    @(negedge clk);
    exp_cnt++;
    check("sim_cnt_b", {16'b0, frame_cnt}, 32'(exp_cnt));
    check("sim_valid_drop", {31'b0, frame_valid}, 32'd0);
`endif

    // Reset mid-frame after 30 pixels
    frame_ready = 1'b1;
    for (int i = 0; i < 30; i++) send_pixel(8'(i + 3), 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid",   {31'b0, frame_valid}, 32'd0);
    check("mid_rst_sof_err", {31'b0, sof_err},     32'd0);
    check("mid_rst_cnt",     {16'b0, frame_cnt},   32'd0);
    check("mid_rst_data0",   frame_data[0],        32'd0);
    check("mid_rst_data29",  frame_data[29],       32'd0);
    check("w_rst_cnt",       {16'b0, w_frame_cnt}, 32'h0000_FFFF);
    @(negedge clk);
    rst_n = 1'b1;
    exp_cnt = 0;
    @(negedge clk);
    check("mid_rst_ready", {31'b0, pix_ready}, 32'd1);
    for (int i = 0; i < N; i++) send_pixel(8'(7 + i), 1'b0, 1'b1);
    check("post_rst_valid", {31'b0, frame_valid}, 32'd1);
    check_frame("post_rst_data");
    @(negedge clk);
    exp_cnt++;
    check("post_rst_cnt", {16'b0, frame_cnt}, 32'(exp_cnt));

    // Counter wrap on the preset instance
    w_frame_ready = 1'b1;
    check("w_ready", {31'b0, w_pix_ready}, 32'd1);
    for (int i = 0; i < WN; i++) begin
      w_pix_valid = 1'b1;
      w_pix_data  = 8'(8'h11 + i);
      @(negedge clk);
    end
    w_pix_valid = 1'b0;
    check("w_valid", {31'b0, w_frame_valid}, 32'd1);
    check("w_data0", w_frame_data[0], 32'h11);
    check("w_data3", w_frame_data[3], 32'h14);
    check("w_cnt_before", {16'b0, w_frame_cnt}, 32'h0000_FFFF);
    @(negedge clk);
    check("w_cnt_wrap", {16'b0, w_frame_cnt}, 32'd0);
    check("w_valid_drop", {31'b0, w_frame_valid}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
